// File: rtl/axis_byte_packer_pkg.sv
// Shared helpers for the byte packer: lane-enable type and the
// count-to-contiguous-tkeep conversion.
package axis_byte_packer_pkg;

  // Widest beat any instance may use; instances truncate to their own N.
  localparam int MAX_N = 32;

  typedef logic [MAX_N-1:0] keep_t;

  // Contiguous lane-enable mask with the low 'cnt' lanes set.
  function automatic keep_t keep_from_count(input int cnt);
    keep_t k;
    k = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < cnt) k[i] = 1'b1;
    end
    return k;
  endfunction

endpackage

// File: rtl/axis_byte_packer.sv
// Byte-wide AXI-Stream to N-byte beat packer with tkeep/tlast.
// Bytes collect in an accumulator; a finished beat moves to the output
// register as soon as the output slot is free, otherwise it is parked in
// the accumulator (pend) and input is stalled.
// Optional feature: define AXIS_PACKER_FLUSH_EN to flush a partial beat
// after FLUSH_CYCLES idle cycles.
module axis_byte_packer
  import axis_byte_packer_pkg::*;
#(
  parameter int N            = 4,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic           aclk,
  input  logic           areset,
  input  logic [7:0]     in_tdata,
  input  logic           in_tvalid,
  input  logic           in_tlast,
  output logic           in_tready,
  output logic [N*8-1:0] out_tdata,
  output logic [N-1:0]   out_tkeep,
  output logic           out_tlast,
  output logic           out_tvalid,
  input  logic           out_tready
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0][7:0] acc_data_reg, acc_data_next;
  logic [CW-1:0]     count_reg, count_next;
  logic              acc_last_reg, acc_last_next;
  logic              pend_reg, pend_next;
  logic [N*8-1:0]    out_data_reg, out_data_next;
  logic [N-1:0]      out_keep_reg, out_keep_next;
  logic              out_last_reg, out_last_next;
  logic              out_valid_reg, out_valid_next;

  logic              accept;
  logic              complete_byte;
  logic              slot_free;
  logic              flush_req;
  logic [CW-1:0]     count_inc;
  logic [N-1:0][7:0] merged_data;

  assign in_tready     = !pend_reg;
  assign accept        = in_tvalid && !pend_reg;
  assign slot_free     = !out_valid_reg || out_tready;
  assign count_inc     = count_reg + 1'b1;
  assign complete_byte = accept && ((count_reg == CW'(N - 1)) || in_tlast);

  // Accumulator contents with the incoming byte dropped into its lane.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign merged_data[gi] = (accept && (count_reg == CW'(gi))) ? in_tdata
                                                                   : acc_data_reg[gi];
    end
  endgenerate

`ifdef AXIS_PACKER_FLUSH_EN
  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  logic [FW-1:0] idle_reg;
  logic          idle_cond;

  assign idle_cond = (count_reg != '0) && !pend_reg && !accept;
  assign flush_req = idle_cond && (idle_reg == FW'(FLUSH_CYCLES - 1));

  // Count idle cycles while a partial beat sits in the accumulator.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      idle_reg <= '0;
    end else if (!idle_cond || flush_req) begin
      idle_reg <= '0;
    end else begin
      idle_reg <= idle_reg + 1'b1;
    end
  end
`else
  assign flush_req = 1'b0;
`endif

  // Decide what the accumulator and output register hold next cycle.
  always_comb begin
    logic              emit;
    logic [N-1:0][7:0] emit_data;
    logic [CW-1:0]     emit_cnt;
    logic              emit_last;

    acc_data_next  = acc_data_reg;
    count_next     = count_reg;
    acc_last_next  = acc_last_reg;
    pend_next      = pend_reg;
    out_data_next  = out_data_reg;
    out_keep_next  = out_keep_reg;
    out_last_next  = out_last_reg;
    out_valid_next = out_valid_reg;
    emit           = 1'b0;
    emit_data      = acc_data_reg;
    emit_cnt       = count_reg;
    emit_last      = acc_last_reg;

    if (pend_reg) begin
      // A parked beat leaves as soon as the output slot opens.
      if (slot_free) emit = 1'b1;
    end else if (complete_byte) begin
      if (slot_free) begin
        emit      = 1'b1;
        emit_data = merged_data;
        emit_cnt  = count_inc;
        emit_last = in_tlast;
      end else begin
        acc_data_next = merged_data;
        count_next    = count_inc;
        acc_last_next = in_tlast;
        pend_next     = 1'b1;
      end
    end else if (accept) begin
      acc_data_next = merged_data;
      count_next    = count_inc;
    end else if (flush_req) begin
      // Timed-out partial beat: never marked as frame end.
      emit_last = 1'b0;
      if (slot_free) begin
        emit = 1'b1;
      end else begin
        acc_last_next = 1'b0;
        pend_next     = 1'b1;
      end
    end

    if (emit) begin
      out_data_next  = emit_data;
      out_keep_next  = N'(keep_from_count(int'(emit_cnt)));
      out_last_next  = emit_last;
      out_valid_next = 1'b1;
      acc_data_next  = '0;
      count_next     = '0;
      acc_last_next  = 1'b0;
      pend_next      = 1'b0;
    end else if (out_tready) begin
      out_valid_next = 1'b0;
    end
  end

  // State registers; reset drops any partial beat.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      acc_data_reg  <= '0;
      count_reg     <= '0;
      acc_last_reg  <= 1'b0;
      pend_reg      <= 1'b0;
      out_data_reg  <= '0;
      out_keep_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      acc_data_reg  <= acc_data_next;
      count_reg     <= count_next;
      acc_last_reg  <= acc_last_next;
      pend_reg      <= pend_next;
      out_data_reg  <= out_data_next;
      out_keep_reg  <= out_keep_next;
      out_last_reg  <= out_last_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign out_tdata  = out_data_reg;
  assign out_tkeep  = out_keep_reg;
  assign out_tlast  = out_last_reg;
  assign out_tvalid = out_valid_reg;

endmodule

// File: tb/tb_axis_byte_packer.sv
// Self-checking bench for axis_byte_packer (N=4): directed cases with
// literal expectations plus a random run against a chunking model.
module tb_axis_byte_packer;

  localparam int N = 4;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [7:0]    in_tdata = '0;
  logic          in_tvalid = 1'b0;
  logic          in_tlast = 1'b0;
  logic          in_tready;
  logic [N*8-1:0] out_tdata;
  logic [N-1:0]  out_tkeep;
  logic          out_tlast;
  logic          out_tvalid;
  logic          out_tready = 1'b1;

  logic          rand_mode = 1'b0;
  logic          fixed_ready = 1'b1;

  int total = 0;
  int bad = 0;
  int beats_seen = 0;

  typedef struct {
    logic [N*8-1:0] data;
    logic [N-1:0]   keep;
    logic           last;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] cur[$];

  axis_byte_packer #(.N(N), .FLUSH_CYCLES(16)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .in_tdata  (in_tdata),
    .in_tvalid (in_tvalid),
    .in_tlast  (in_tlast),
    .in_tready (in_tready),
    .out_tdata (out_tdata),
    .out_tkeep (out_tkeep),
    .out_tlast (out_tlast),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready)
  );

  always #5 aclk = ~aclk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endfunction

  // Model: a frame is cut into N-byte chunks; the tail chunk carries tlast.
  function automatic void model_emit(logic last);
    beat_t bt;
    bt.data = '0;
    bt.keep = '0;
    foreach (cur[i]) begin
      bt.data[8*i +: 8] = cur[i];
      bt.keep[i] = 1'b1;
    end
    bt.last = last;
    exp_q.push_back(bt);
    cur.delete();
  endfunction

  function automatic void model_push(logic [7:0] b, logic last);
    cur.push_back(b);
    if (cur.size() == N || last) model_emit(last);
  endfunction

  // Downstream ready: fixed in directed tests, random in the soak run.
  always @(negedge aclk) begin
    out_tready = rand_mode ? ($urandom_range(0, 3) != 0) : fixed_ready;
  end

  // Compare process: sampled just before each rising edge.
  logic  prev_hold = 1'b0;
  beat_t prev;
  always begin
    @(negedge aclk);
    #4;
    if (areset || !out_tvalid) begin
      prev_hold = 1'b0;
    end else begin
      check("keep_nonzero", 64'(out_tkeep != '0), 64'd1);
      if (prev_hold) begin
        check("hold_data", 64'(out_tdata), 64'(prev.data));
        check("hold_keep_last", 64'({out_tkeep, out_tlast}), 64'({prev.keep, prev.last}));
      end
      if (out_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(out_tvalid), 64'd0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", 64'(out_tdata), 64'(e.data));
          check("beat_keep", 64'(out_tkeep), 64'(e.keep));
          check("beat_last", 64'(out_tlast), 64'(e.last));
        end
        beats_seen++;
      end
      prev_hold = !out_tready;
      prev.data = out_tdata;
      prev.keep = out_tkeep;
      prev.last = out_tlast;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last);
    int t;
    in_tvalid = 1'b1;
    in_tdata  = b;
    in_tlast  = last;
    t = 0;
    while (!in_tready && t < 200) begin
      @(negedge aclk);
      t++;
    end
    if (!in_tready) begin
      check("send_timeout", 64'(in_tready), 64'd1);
    end else begin
      model_push(b, last);
      @(negedge aclk);
    end
  endtask

  task automatic idle(input int n);
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    repeat (n) @(negedge aclk);
  endtask

  task automatic send_str(input string s, input logic last_at_end);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], last_at_end && (i == s.len() - 1));
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge aclk);
      t++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int t;
    int seen0;

    // Reset state
    repeat (3) @(negedge aclk);
    check("rst_tvalid", 64'(out_tvalid), 64'd0);
    check("rst_tdata", 64'(out_tdata), 64'd0);
    check("rst_tkeep_tlast", 64'({out_tkeep, out_tlast}), 64'd0);
    check("rst_in_tready", 64'(in_tready), 64'd1);
    areset = 1'b0;
    @(negedge aclk);

    // 1: full beat with tlast; visible one cycle after the last byte
    send_str("0123", 1'b1);
    idle(0);
    check("t1_valid", 64'(out_tvalid), 64'd1);
    check("t1_data", 64'(out_tdata), 64'h33323130);
    check("t1_keep_last", 64'({out_tkeep, out_tlast}), 64'h1F);
    idle(2);
    wait_drain();

    // 2: full beat then partial tail
    send_str("ABCD", 1'b0);
    check("t2a_data", 64'(out_tdata), 64'h44434241);
    check("t2a_keep_last", 64'({out_tkeep, out_tlast}), 64'h1E);
    send_str("EF", 1'b1);
    idle(0);
    check("t2b_data", 64'(out_tdata), 64'h00004645);
    check("t2b_keep_last", 64'({out_tkeep, out_tlast}), 64'h07);
    idle(2);
    wait_drain();

    // 3: backpressure, second beat parks and input stalls
    fixed_ready = 1'b0;
    @(negedge aclk);
    seen0 = beats_seen;
    send_str("ABCDEFGH", 1'b0);
    idle(0);
    check("t3_in_tready", 64'(in_tready), 64'd0);
    check("t3_held_data", 64'(out_tdata), 64'h44434241);
    idle(3);
    fixed_ready = 1'b1;
    wait_drain();
    check("t3_beats", 64'(beats_seen - seen0), 64'd2);

    // 4: single-byte frame
    send_byte(8'h5A, 1'b1);
    idle(0);
    check("t4_data", 64'(out_tdata), 64'h0000005A);
    check("t4_keep_last", 64'({out_tkeep, out_tlast}), 64'h03);
    idle(2);
    wait_drain();

    // 5: reset mid-frame discards the partial beat
    send_str("PQ", 1'b0);
    idle(1);
    areset = 1'b1;
    #1;
    check("t5_tvalid", 64'(out_tvalid), 64'd0);
    check("t5_in_tready", 64'(in_tready), 64'd1);
    cur.delete();
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    send_str("WXYZ", 1'b1);
    idle(0);
    check("t5_data", 64'(out_tdata), 64'h5A595857);
    check("t5_keep_last", 64'({out_tkeep, out_tlast}), 64'h1F);
    idle(2);
    wait_drain();

    // 6: idle partial beat
    seen0 = beats_seen;
    send_str("abc", 1'b0);
    in_tvalid = 1'b0;
`ifdef AXIS_PACKER_FLUSH_EN
    model_emit(1'b0);
    t = 0;
    while (!out_tvalid && t < 40) begin
      @(negedge aclk);
      t++;
    end
    check("t6_flush_latency", 64'(t), 64'd16);
    check("t6_data", 64'(out_tdata), 64'h00636261);
    check("t6_keep_last", 64'({out_tkeep, out_tlast}), 64'h0E);
    idle(2);
    wait_drain();
`else
    idle(30);
    check("t6_no_beat", 64'(beats_seen - seen0), 64'd0);
    check("t6_no_valid", 64'(out_tvalid), 64'd0);
    send_byte("d", 1'b1);
    idle(0);
    check("t6_data", 64'(out_tdata), 64'h64636261);
    check("t6_keep_last", 64'({out_tkeep, out_tlast}), 64'h1F);
    idle(2);
    wait_drain();
`endif

    // Random run
    rand_mode = 1'b1;
    for (int f = 0; f < 500; f++) begin
      int len;
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        send_byte(8'($urandom), i == len - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    idle(1);
    rand_mode = 1'b0;
    fixed_ready = 1'b1;
    wait_drain();
    check("rand_partial_left", 64'(cur.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
